// File: rtl/pkt_route_arbiter.sv
// rtl/pkt_route_arbiter.sv - round-robin packet scheduler: header latch, route lookup handoff, egress AXIS mux
// Optional stall watchdog enabled by defining ARB_STALL_WATCHDOG_EN.
module pkt_route_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_W         = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    axis_clk,
  input  logic                    axis_resetn,
  input  logic [NUM_PORTS-1:0]    hdr_valid,
  output logic [NUM_PORTS-1:0]    hdr_ready,
  input  logic [48*NUM_PORTS-1:0] hdr_dest_addr,
  input  logic [32*NUM_PORTS-1:0] hdr_ip_dest_addr,
  input  logic [16*NUM_PORTS-1:0] hdr_udp_dest_port,
  input  logic [NUM_PORTS-1:0]    hdr_encap,
  output logic                    rt_valid,
  input  logic                    rt_ready,
  output logic [PORT_W-1:0]       rt_port,
  output logic [47:0]             rt_dest_addr,
  output logic [31:0]             rt_ip_dest_addr,
  output logic [15:0]             rt_udp_dest_port,
  output logic                    rt_encap,
  input  logic [32*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [4*NUM_PORTS-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]    s_axis_tlast,
  output logic [NUM_PORTS-1:0]    s_axis_tready,
  output logic [31:0]             m_axis_tdata,
  output logic [3:0]              m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    abort
);

  typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [NUM_PORTS-1:0]   pending_q;
  logic [PORT_W-1:0]      last_grant_q;
  logic [PORT_W-1:0]      grant_q;
  logic [PORT_W-1:0]      next_grant;
  logic                   found;
  logic                   do_grant;
  logic                   beat;
  logic                   pkt_done;
  logic                   wd_fire;
  logic                   release_pkt;
  logic [NUM_PORTS-1:0]   hdr_ready_q;
  logic                   abort_q;

  logic [47:0] hold_dest [NUM_PORTS];
  logic [31:0] hold_ip   [NUM_PORTS];
  logic [15:0] hold_udp  [NUM_PORTS];
  logic        hold_enc  [NUM_PORTS];

  logic [47:0] rt_dest_q;
  logic [31:0] rt_ip_q;
  logic [15:0] rt_udp_q;
  logic        rt_enc_q;
  logic [PORT_W-1:0] rt_port_q;

  function automatic logic [PORT_W-1:0] wrap_idx(input logic [PORT_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PORT_W'(s);
  endfunction

  // First pending port after the last served one, wrapping around.
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && pending_q[wrap_idx(last_grant_q, k)]) begin
        found      = 1'b1;
        next_grant = wrap_idx(last_grant_q, k);
      end
    end
  end

  assign beat        = (state_q == STREAM) && s_axis_tvalid[grant_q] && m_axis_tready;
  assign pkt_done    = beat && s_axis_tlast[grant_q];
  assign release_pkt = pkt_done || wd_fire;

`ifdef ARB_STALL_WATCHDOG_EN
  logic [15:0] stall_q;

  assign wd_fire = (state_q == STREAM) && !beat && ((stall_q + 16'd1) == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge axis_clk) begin
    if (!axis_resetn || state_q != STREAM || beat) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 16'd1;
    end
  end
`else
  logic unused_cfg;

  assign wd_fire    = 1'b0;
  assign unused_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge axis_clk) begin
    if (!axis_resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rt_valid is exactly "in HDR", so HDR only leaves on the lookup handshake.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          do_grant = 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        if (rt_ready) state_d = STREAM;
      end
      STREAM: begin
        if (release_pkt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_resetn) begin
      pending_q    <= '0;
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      grant_q      <= '0;
      hdr_ready_q  <= '0;
      abort_q      <= 1'b0;
      rt_port_q    <= '0;
      rt_dest_q    <= '0;
      rt_ip_q      <= '0;
      rt_udp_q     <= '0;
      rt_enc_q     <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        hold_dest[i] <= '0;
        hold_ip[i]   <= '0;
        hold_udp[i]  <= '0;
        hold_enc[i]  <= 1'b0;
      end
    end else begin
      hdr_ready_q <= '0;
      abort_q     <= wd_fire;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (hdr_valid[i] && !pending_q[i]) begin
          pending_q[i] <= 1'b1;
          hold_dest[i] <= hdr_dest_addr[48*i +: 48];
          hold_ip[i]   <= hdr_ip_dest_addr[32*i +: 32];
          hold_udp[i]  <= hdr_udp_dest_port[16*i +: 16];
          hold_enc[i]  <= hdr_encap[i];
        end
      end
      if (do_grant) begin
        grant_q   <= next_grant;
        rt_port_q <= next_grant;
        rt_dest_q <= hold_dest[next_grant];
        rt_ip_q   <= hold_ip[next_grant];
        rt_udp_q  <= hold_udp[next_grant];
        rt_enc_q  <= hold_enc[next_grant];
      end
      // The releasing port is still pending this cycle, so its capture above is ignored.
      if (release_pkt) begin
        pending_q[grant_q]   <= 1'b0;
        hdr_ready_q[grant_q] <= 1'b1;
        last_grant_q         <= grant_q;
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state_q == STREAM) begin
      s_axis_tready[grant_q] = m_axis_tready;
      m_axis_tdata           = s_axis_tdata[32*int'(grant_q) +: 32];
      m_axis_tkeep           = s_axis_tkeep[4*int'(grant_q) +: 4];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
    end
  end

  assign rt_valid         = (state_q == HDR);
  assign rt_port          = rt_port_q;
  assign rt_dest_addr     = rt_dest_q;
  assign rt_ip_dest_addr  = rt_ip_q;
  assign rt_udp_dest_port = rt_udp_q;
  assign rt_encap         = rt_enc_q;
  assign hdr_ready        = hdr_ready_q;
  assign abort            = abort_q;

endmodule

// File: tb/tb_pkt_route_arbiter.sv
// tb/tb_pkt_route_arbiter.sv - self-checking bench for pkt_route_arbiter against a packet-level model
module tb_pkt_route_arbiter;
  localparam int N = 4;

  logic            axis_clk = 1'b0;
  logic            axis_resetn;
  logic [N-1:0]    hdr_valid, hdr_ready, hdr_encap;
  logic [48*N-1:0] hdr_dest_addr;
  logic [32*N-1:0] hdr_ip_dest_addr;
  logic [16*N-1:0] hdr_udp_dest_port;
  logic            rt_valid, rt_ready, rt_encap;
  logic [1:0]      rt_port;
  logic [47:0]     rt_dest_addr;
  logic [31:0]     rt_ip_dest_addr;
  logic [15:0]     rt_udp_dest_port;
  logic [32*N-1:0] s_axis_tdata;
  logic [4*N-1:0]  s_axis_tkeep;
  logic [N-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0]     m_axis_tdata;
  logic [3:0]      m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready, abort;

  always #5 axis_clk = ~axis_clk;

  pkt_route_arbiter #(.NUM_PORTS(N), .PORT_W(2), .TIMEOUT_CYCLES(1024)) dut (
    .axis_clk(axis_clk), .axis_resetn(axis_resetn),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dest_addr(hdr_dest_addr),
    .hdr_ip_dest_addr(hdr_ip_dest_addr), .hdr_udp_dest_port(hdr_udp_dest_port), .hdr_encap(hdr_encap),
    .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_port(rt_port), .rt_dest_addr(rt_dest_addr),
    .rt_ip_dest_addr(rt_ip_dest_addr), .rt_udp_dest_port(rt_udp_dest_port), .rt_encap(rt_encap),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .abort(abort)
  );

  typedef struct packed {
    logic [47:0] dest;
    logic [31:0] ip;
    logic [15:0] udp;
    logic        enc;
  } hdr_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pending set, service phase, packets held by each source
  hdr_t        exp_hdr [N];
  logic [N-1:0] m_pend;
  int          m_phase;
  int          m_grant, m_last;
  logic [31:0] src_data [N][16];
  logic [3:0]  src_keep [N][16];
  int          src_len [N];
  int          src_pos [N];
  int          cyc, cap_cyc, grant_cyc, rel_cyc;
  int          grant_log[$];
  int          gap_log[$];
  logic [3:0]  keep_log[$];
  int          hr_count [N];
  int          beats_out;

  logic [N-1:0] req_mask;
  hdr_t         req_hdr [N];
  int           req_len [N];
  logic [3:0]   req_lastkeep [N];
  int           vprob, rprob, tready_mode;
  logic         rt_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic hdr_t rand_hdr();
    hdr_t h;
    h.dest = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    h.ip   = $urandom;
    h.udp  = 16'($urandom);
    h.enc  = 1'($urandom);
    return h;
  endfunction

  task automatic req(input int p, input logic [47:0] dest, input int len, input logic [3:0] lk);
    req_mask[p]     = 1'b1;
    req_hdr[p]      = rand_hdr();
    req_hdr[p].dest = dest;
    req_len[p]      = len;
    req_lastkeep[p] = lk;
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_phase = 0;
    m_grant = 0;
    m_last  = N - 1;
    rel_cyc = -1;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, clock, advance model, check registers
  task automatic step();
    logic [N-1:0] pend_b, e_tready, hr_exp;
    logic         bt, lastbeat, rt_hs;
    hdr_t         h;
    hdr_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (req_mask[i]) begin
        hdr_valid[i] = 1'b1;
        h = m_pend[i] ? rand_hdr() : req_hdr[i];
        hdr_dest_addr[48*i +: 48]     = h.dest;
        hdr_ip_dest_addr[32*i +: 32]  = h.ip;
        hdr_udp_dest_port[16*i +: 16] = h.udp;
        hdr_encap[i]                  = h.enc;
      end
      if (src_pos[i] < src_len[i]) begin
        s_axis_tvalid[i]       = ($urandom_range(99) < 32'(vprob));
        s_axis_tdata[32*i +: 32] = src_data[i][src_pos[i]];
        s_axis_tkeep[4*i +: 4]   = src_keep[i][src_pos[i]];
        s_axis_tlast[i]        = (src_pos[i] == src_len[i] - 1);
      end else begin
        s_axis_tvalid[i]       = 1'b0;
        s_axis_tdata[32*i +: 32] = $urandom;
        s_axis_tkeep[4*i +: 4]   = 4'h0;
        s_axis_tlast[i]        = 1'b0;
      end
    end
    m_axis_tready = (tready_mode == 1) ? ~cyc[0] : ($urandom_range(99) < 32'(rprob));
    rt_ready = !rt_hold;
    #1;
    e_tready = '0;
    if (m_phase == 2) e_tready[m_grant] = m_axis_tready;
    chk("s_axis_tready", 64'(s_axis_tready), 64'(e_tready));
    chk("m_axis_tvalid", 64'(m_axis_tvalid), 64'(m_phase == 2 && s_axis_tvalid[m_grant]));
    bt = (m_phase == 2) && s_axis_tvalid[m_grant] && m_axis_tready;
    lastbeat = 1'b0;
    if (bt) begin
      chk("m_axis_tdata", 64'(m_axis_tdata), 64'(src_data[m_grant][src_pos[m_grant]]));
      chk("m_axis_tkeep", 64'(m_axis_tkeep), 64'(src_keep[m_grant][src_pos[m_grant]]));
      lastbeat = (src_pos[m_grant] == src_len[m_grant] - 1);
      chk("m_axis_tlast", 64'(m_axis_tlast), 64'(lastbeat));
      keep_log.push_back(m_axis_tkeep);
      beats_out++;
      src_pos[m_grant]++;
    end
    rt_hs  = (m_phase == 1) && rt_ready;
    pend_b = m_pend;
    @(posedge axis_clk);
    hr_exp = '0;
    for (int i = 0; i < N; i++) begin
      if (req_mask[i] && !pend_b[i]) begin
        m_pend[i]  = 1'b1;
        exp_hdr[i] = req_hdr[i];
        cap_cyc    = cyc;
        src_len[i] = req_len[i];
        src_pos[i] = 0;
        for (int b = 0; b < req_len[i]; b++) begin
          src_data[i][b] = $urandom;
          src_keep[i][b] = (b == req_len[i] - 1) ? req_lastkeep[i] : 4'hF;
        end
      end
    end
    if (lastbeat) begin
      m_pend[m_grant] = 1'b0;
      hr_exp[m_grant] = 1'b1;
      m_last  = m_grant;
      m_phase = 0;
      rel_cyc = cyc;
    end else if (m_phase == 1 && rt_hs) begin
      m_phase = 2;
    end else if (m_phase == 0 && pend_b != '0) begin
      m_grant   = rr_pick(pend_b, m_last);
      m_phase   = 1;
      grant_cyc = cyc + 1;
      grant_log.push_back(m_grant);
      if (rel_cyc >= 0) gap_log.push_back(grant_cyc - rel_cyc);
    end
    #1;
    chk("rt_valid", 64'(rt_valid), 64'(m_phase == 1));
    if (m_phase == 1) begin
      chk("rt_port", 64'(rt_port), 64'(m_grant));
      chk("rt_dest_addr", 64'(rt_dest_addr), 64'(exp_hdr[m_grant].dest));
      chk("rt_ip_dest_addr", 64'(rt_ip_dest_addr), 64'(exp_hdr[m_grant].ip));
      chk("rt_udp_dest_port", 64'(rt_udp_dest_port), 64'(exp_hdr[m_grant].udp));
      chk("rt_encap", 64'(rt_encap), 64'(exp_hdr[m_grant].enc));
    end
    chk("hdr_ready", 64'(hdr_ready), 64'(hr_exp));
    for (int i = 0; i < N; i++) if (hdr_ready[i]) hr_count[i]++;
`ifndef ARB_STALL_WATCHDOG_EN
    chk("abort", 64'(abort), 64'd0);
`endif
    cyc++;
    req_mask = '0;
    @(negedge axis_clk);
  endtask

  task automatic do_reset();
    axis_resetn   = 1'b0;
    hdr_valid     = '0;
    s_axis_tvalid = '1;
    m_axis_tready = 1'b1;
    rt_ready      = 1'b1;
    @(posedge axis_clk);
    #1;
    chk("rst_rt_valid", 64'(rt_valid), 64'd0);
    chk("rst_rt_port", 64'(rt_port), 64'd0);
    chk("rst_rt_dest", 64'(rt_dest_addr), 64'd0);
    chk("rst_rt_ip", 64'(rt_ip_dest_addr), 64'd0);
    chk("rst_rt_udp", 64'(rt_udp_dest_port), 64'd0);
    chk("rst_rt_encap", 64'(rt_encap), 64'd0);
    chk("rst_hdr_ready", 64'(hdr_ready), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_abort", 64'(abort), 64'd0);
    model_reset();
    @(negedge axis_clk);
    axis_resetn = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_pend != '0 || m_phase != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(m_pend != '0 || m_phase != 0), 64'd0);
  endtask

  initial begin
    hdr_valid = '0; hdr_encap = '0; hdr_dest_addr = '0; hdr_ip_dest_addr = '0; hdr_udp_dest_port = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    m_axis_tready = 1'b0; rt_ready = 1'b0; axis_resetn = 1'b0;
    req_mask = '0; rt_hold = 1'b0; vprob = 100; rprob = 100; tready_mode = 0;
    cyc = 0; cap_cyc = 0; grant_cyc = 0; beats_out = 0;
    for (int i = 0; i < N; i++) hr_count[i] = 0;
    model_reset();

    // Single packet on port 2
    do_reset();
    req(2, 48'h0011_2233_4455, 3, 4'hF);
    beats_out = 0;
    step();
    drain(50);
    chk("lat_hdr_to_rt", 64'(grant_cyc - cap_cyc), 64'd2);
    chk("p2_grant", 64'(grant_log[grant_log.size()-1]), 64'd2);
    chk("p2_beats", 64'(beats_out), 64'd3);
    chk("p2_hdr_ready_cnt", 64'(hr_count[2]), 64'd1);
    chk("other_hdr_ready_cnt", 64'(hr_count[0] + hr_count[1] + hr_count[3]), 64'd0);

    // All ports at once, then 1 and 0 re-request
    do_reset();
    grant_log.delete();
    gap_log.delete();
    for (int i = 0; i < N; i++) req(i, 48'(i + 16), 2, 4'hF);
    step();
    drain(200);
    chk("rr_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", 64'(grant_log[i]), 64'(i));
    chk("gap_count", 64'(gap_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("tlast_to_rt", 64'(gap_log[i]), 64'd2);
    grant_log.delete();
    req(1, 48'hA1, 2, 4'hF);
    req(0, 48'hA0, 2, 4'hF);
    step();
    drain(100);
    chk("wrap_first", 64'(grant_log[0]), 64'd0);
    chk("wrap_second", 64'(grant_log[1]), 64'd1);

    // Route lookup back-pressure
    rt_hold = 1'b1;
    req(3, 48'hBEEF, 2, 4'hF);
    step();
    step();
    begin
      int held;
      held = 0;
      for (int n = 0; n < 10; n++) begin
        step();
        if (rt_valid) held++;
      end
      chk("rt_hold_cycles", 64'(held), 64'd10);
    end
    rt_hold = 1'b0;
    drain(50);

    // Toggling egress ready, short final beat
    tready_mode = 1;
    keep_log.delete();
    beats_out = 0;
    req(1, 48'hCAFE, 5, 4'h3);
    step();
    drain(100);
    chk("toggle_beats", 64'(beats_out), 64'd5);
    for (int i = 0; i < 4; i++) chk("toggle_keep", 64'(keep_log[i]), 64'hF);
    chk("toggle_last_keep", 64'(keep_log[4]), 64'h3);
    tready_mode = 0;

    // Reset in the middle of a packet
    beats_out = 0;
    req(0, 48'hD00D, 4, 4'hF);
    step();
    for (int n = 0; n < 20 && beats_out < 1; n++) step();
    chk("pre_reset_beats", 64'(beats_out), 64'd1);
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) hr_count[i] = 0;
    req(2, 48'hF00D, 2, 4'hF);
    step();
    drain(50);
    chk("post_reset_grant", 64'(grant_log[0]), 64'd2);
    chk("post_reset_release", 64'(hr_count[2]), 64'd1);

    // Randomized traffic
    vprob = 70;
    rprob = 60;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(99) < 20) req(i, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
                                         int'($urandom_range(8, 1)), 4'($urandom_range(15, 1)));
      rt_hold = ($urandom_range(99) < 30);
      step();
    end
    rt_hold = 1'b0;
    drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
